// File: rtl/cpu_pkg.sv
// cpu_pkg: shared architectural defaults and register-file types
package cpu_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF = $clog2(NREGS_DEF);
  localparam bit ZERO_REG_DEF = 1'b1;
  typedef logic [AW_DEF-1:0] regaddr_t;
  typedef logic [XLEN_DEF-1:0] word_t;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read/write/scoreboard bus between the ID stage and the register file
interface regfile_mp_if
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = 2,
  parameter int NWR = 2
);
  localparam int AW = $clog2(NREGS);
  logic [NWR-1:0] we;
  logic [NWR*AW-1:0] waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0] rbusy;
  logic alloc_en;
  logic [AW-1:0] alloc_addr;
  logic flush;
  modport master (output we, waddr, wdata, raddr, alloc_en, alloc_addr, flush, input rdata, rbusy);
  modport slave (input we, waddr, wdata, raddr, alloc_en, alloc_addr, flush, output rdata, rbusy);
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with alloc/write-clear/flush and bypass-aware rbusy
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = 2,
  parameter int NWR = 2,
  parameter bit ZERO_REG = ZERO_REG_DEF,
  localparam int AW = $clog2(NREGS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NWR-1:0] we,
  input  logic [NWR*AW-1:0] waddr,
  input  logic alloc_en,
  input  logic [AW-1:0] alloc_addr,
  input  logic flush,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD-1:0] rbusy
);
  logic [NREGS-1:0] busy, busy_nxt, wr_hit, alloc_vec;
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NWR; i++) if (we[i]) wr_hit[waddr[i*AW +: AW]] = 1'b1;
    alloc_vec = alloc_en ? NREGS'(1) << alloc_addr : '0;
    busy_nxt = flush ? '0 : (busy & ~wr_hit) | alloc_vec;
    if (ZERO_REG) busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else busy <= busy_nxt;
  // a matching write this cycle supplies the value through the bypass, so it is not busy
  for (genvar p = 0; p < NRD; p++) begin : g_rb
    assign rbusy[p] = busy[raddr[p*AW +: AW]] & ~wr_hit[raddr[p*AW +: AW]];
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write bypass, fixed write priority and busy scoreboard
module regfile_mp
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = 2,
  parameter int NWR = 2,
  parameter bit ZERO_REG = ZERO_REG_DEF,
  localparam int AW = $clog2(NREGS)
) (
  input logic clk,
  input logic rst_n,
  regfile_mp_if.slave bus
);
  logic [XLEN-1:0] mem [NREGS];
  // later ports are assigned last, so the highest index wins on a collision
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    else
      for (int i = 0; i < NWR; i++)
        if (bus.we[i] && !(ZERO_REG && bus.waddr[i*AW +: AW] == '0))
          mem[bus.waddr[i*AW +: AW]] <= bus.wdata[i*XLEN +: XLEN];
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] ra;
    logic [XLEN-1:0] byp;
    assign ra = bus.raddr[p*AW +: AW];
    always_comb begin
      byp = mem[ra];
      for (int j = 0; j < NWR; j++)
        byp = (bus.we[j] && bus.waddr[j*AW +: AW] == ra) ? bus.wdata[j*XLEN +: XLEN] : byp;
    end
    assign bus.rdata[p*XLEN +: XLEN] = (ZERO_REG && ra == '0) ? '0 : byp;
  end
  regfile_scoreboard #(.NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk),
    .rst_n(rst_n),
    .we(bus.we),
    .waddr(bus.waddr),
    .alloc_en(bus.alloc_en),
    .alloc_addr(bus.alloc_addr),
    .flush(bus.flush),
    .raddr(bus.raddr),
    .rbusy(bus.rbusy)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vector table plus reset sequence for regfile_mp
module tb_regfile_mp;
  import cpu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus ();
  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1'b1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  typedef struct {
    logic [1:0] we;
    regaddr_t wa0, wa1;
    word_t wd0, wd1;
    regaddr_t ra0, ra1;
    logic ae;
    regaddr_t aa;
    logic fl;
    word_t e0, e1;
    logic [1:0] eb;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t v(logic [1:0] we, regaddr_t wa0, word_t wd0, regaddr_t wa1, word_t wd1,
                             regaddr_t ra0, regaddr_t ra1, logic ae, regaddr_t aa, logic fl,
                             word_t e0, word_t e1, logic [1:0] eb);
    vec_t t;
    t.we = we; t.wa0 = wa0; t.wd0 = wd0; t.wa1 = wa1; t.wd1 = wd1;
    t.ra0 = ra0; t.ra1 = ra1; t.ae = ae; t.aa = aa; t.fl = fl;
    t.e0 = e0; t.e1 = e1; t.eb = eb;
    return t;
  endfunction
  task automatic drive(vec_t t);
    bus.we = t.we;
    bus.waddr = {t.wa1, t.wa0};
    bus.wdata = {t.wd1, t.wd0};
    bus.raddr = {t.ra1, t.ra0};
    bus.alloc_en = t.ae;
    bus.alloc_addr = t.aa;
    bus.flush = t.fl;
  endtask
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic chk_all(string tag, word_t e0, word_t e1, logic [1:0] eb);
    chk({tag, " rdata0"}, bus.rdata[31:0], e0);
    chk({tag, " rdata1"}, bus.rdata[63:32], e1);
    chk({tag, " rbusy"}, {30'd0, bus.rbusy}, {30'd0, eb});
  endtask
  initial begin
    tv.push_back(v(2'b00, 0, 0, 0, 0, 5, 3, 0, 0, 0, 0, 0, 2'b00));
    tv.push_back(v(2'b01, 3, 32'h12345678, 0, 0, 3, 3, 0, 0, 0, 32'h12345678, 32'h12345678, 2'b00));
    tv.push_back(v(2'b00, 0, 0, 0, 0, 3, 3, 0, 0, 0, 32'h12345678, 32'h12345678, 2'b00));
    tv.push_back(v(2'b10, 0, 0, 7, 32'hA5A5A5A5, 7, 3, 0, 0, 0, 32'hA5A5A5A5, 32'h12345678, 2'b00));
    tv.push_back(v(2'b11, 9, 32'h1111, 9, 32'h2222, 9, 9, 0, 0, 0, 32'h2222, 32'h2222, 2'b00));
    tv.push_back(v(2'b00, 0, 0, 0, 0, 9, 7, 0, 0, 0, 32'h2222, 32'hA5A5A5A5, 2'b00));
    tv.push_back(v(2'b01, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00));
    tv.push_back(v(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    tv.push_back(v(2'b00, 0, 0, 0, 0, 4, 4, 1, 4, 0, 0, 0, 2'b00));
    tv.push_back(v(2'b00, 0, 0, 0, 0, 4, 3, 0, 0, 0, 0, 32'h12345678, 2'b01));
    tv.push_back(v(2'b01, 4, 32'h44, 0, 0, 4, 9, 1, 4, 0, 32'h44, 32'h2222, 2'b00));
    tv.push_back(v(2'b00, 0, 0, 0, 0, 4, 4, 0, 0, 0, 32'h44, 32'h44, 2'b11));
    tv.push_back(v(2'b10, 0, 0, 4, 32'h55, 4, 4, 0, 0, 0, 32'h55, 32'h55, 2'b00));
    tv.push_back(v(2'b00, 0, 0, 0, 0, 4, 4, 0, 0, 0, 32'h55, 32'h55, 2'b00));
    tv.push_back(v(2'b00, 0, 0, 0, 0, 6, 6, 1, 6, 1, 0, 0, 2'b00));
    tv.push_back(v(2'b00, 0, 0, 0, 0, 6, 6, 0, 0, 0, 0, 0, 2'b00));
    tv.push_back(v(2'b00, 0, 0, 0, 0, 2, 2, 1, 6, 0, 0, 0, 2'b00));
    tv.push_back(v(2'b00, 0, 0, 0, 0, 6, 2, 1, 2, 0, 0, 0, 2'b01));
    tv.push_back(v(2'b00, 0, 0, 0, 0, 6, 2, 0, 0, 1, 0, 0, 2'b11));
    tv.push_back(v(2'b00, 0, 0, 0, 0, 6, 2, 0, 0, 0, 0, 0, 2'b00));
    tv.push_back(v(2'b01, 5, 32'hDEADBEEF, 0, 0, 5, 3, 0, 0, 0, 32'hDEADBEEF, 32'h12345678, 2'b00));
    tv.push_back(v(2'b00, 0, 0, 0, 0, 5, 3, 1, 5, 0, 32'hDEADBEEF, 32'h12345678, 2'b00));
    tv.push_back(v(2'b00, 0, 0, 0, 0, 5, 3, 0, 0, 0, 32'hDEADBEEF, 32'h12345678, 2'b01));
    drive(v(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    foreach (tv[k]) begin
      @(negedge clk);
      drive(tv[k]);
      #2;
      chk_all($sformatf("row%0d", k), tv[k].e0, tv[k].e1, tv[k].eb);
    end
    @(negedge clk);
    drive(v(2'b01, 5, 32'hCAFEF00D, 0, 0, 5, 3, 1, 5, 0, 0, 0, 2'b00));
    rst_n = 1'b0;
    @(negedge clk);
    drive(v(2'b00, 0, 0, 0, 0, 5, 3, 0, 0, 0, 0, 0, 2'b00));
    #2;
    chk_all("in_reset", 32'h0, 32'h0, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk_all("post_reset", 32'h0, 32'h0, 2'b00);
    @(negedge clk);
    drive(v(2'b00, 0, 0, 0, 0, 5, 9, 0, 0, 0, 0, 0, 2'b00));
    #2;
    chk_all("post_reset2", 32'h0, 32'h0, 2'b00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a per-register busy scoreboard, replacing the single-write, two-read register file in the ID stage of the pipeline. It provides `NRD` combinational read ports with same-cycle write bypass and `NWR` clocked write ports with fixed priority. It also tracks which registers have an in-flight producer so the hazard unit can stall dependent instructions. Register 0 is optionally hard-wired to zero.

## Interface
Parameters:
- `XLEN`, 32, data width of each register.
- `NREGS`, 32, number of architectural registers; must be a power of two, ≥ 2.
- `NRD`, 2, number of read ports.
- `NWR`, 2, number of write ports.
- `ZERO_REG`, 1, when 1 register 0 always reads as 0; writes and allocates to it are ignored.
- `AW`, derived as `$clog2(NREGS)`; not overridable.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `we`  in  NWR  write enable per write port.
- `waddr`  in  NWR*AW  write addresses, packed; port i is `[i*AW +: AW]`.
- `wdata`  in  NWR*XLEN  write data, packed the same way.
- `raddr`  in  NRD*AW  read addresses, packed.
- `rdata`  out  NRD*XLEN  read data, packed, combinational.
- `rbusy`  out  NRD  read port i's register has an outstanding producer.
- `alloc_en`  in  1  mark `alloc_addr` busy (destination of the instruction issuing this cycle).
- `alloc_addr`  in  AW  register to mark busy.
- `flush`  in  1  clear all busy bits (pipeline flush); register data is untouched.

## Operation
- **Storage.** Storage is `NREGS × XLEN` data plus an `NREGS`-bit `busy` vector.
- **Write.** On each rising edge, for each port i with `we[i]=1`, register `waddr[i]` takes `wdata[i]`. When several ports hit the same address, the highest-index port wins.
- **Read.** `rdata[i]` is selected from the following, in priority order:
  - 0 if `ZERO_REG` and `raddr[i]==0`;
  - otherwise, the data of the highest-index write port with `we=1` and matching `waddr` in the current cycle (write-through bypass);
  - otherwise, the stored value.
- **Scoreboard next-state, per register r, evaluated in this order:**
  - `flush` clears every busy bit;
  - else `alloc_en && alloc_addr==r` sets busy[r];
  - else any `we[i] && waddr[i]==r` clears busy[r];
  - else busy[r] holds.
- **Scoreboard collisions.**
  - Alloc and write to the same register in the same cycle leaves it busy: the new producer is younger.
  - Alloc and `flush` in the same cycle: the flush wins and busy stays 0.
- **rbusy.** `rbusy[i] = busy[raddr[i]]` and not bypassed. Any matching write this cycle forces `rbusy[i]=0`, because the value is available via the bypass. It is also forced to 0 for register 0 when `ZERO_REG=1`.
- **Register 0 with `ZERO_REG=1`.** Writes and allocates to register 0 are discarded, and busy[0] stays 0.
- **Reset.** `rst_n=0` asynchronously clears all registers to 0 and all busy bits to 0.
  - After reset, `rdata` equals the bypass or 0, and `rbusy` is 0.
  - Reset asserted mid-operation discards any write or allocate in that cycle.

## Timing
- Read latency is zero: `rdata`/`rbusy` are a combinational function of `raddr`, `we`, `waddr`, `wdata` and state.
- Write latency is one edge: the stored value is visible through the storage path from the cycle after `we`, and through the bypass in the same cycle.
- Alloc latency is one edge: `rbusy` reflects an allocate from the following cycle.
- There is no handshake. Producers must not write a register that has no allocation; the block tolerates it, and the write simply updates data and clears busy.
- The combinational paths from `raddr` and from `waddr`/`wdata` to `rdata` are accepted. Timing closure assumes `NWR ≤ 4`.

## Structure
- **Shared package `cpu_pkg`:**
  - `XLEN` and `NREGS` defaults;
  - `regaddr_t` (logic [AW-1:0]) and `word_t` (logic [XLEN-1:0]);
  - the `ZERO_REG` default.
- **Sub-module `regfile_scoreboard`:** holds the busy vector, the alloc/clear/flush logic and `rbusy` generation. Its ports are `clk`, `rst_n`, `we`, `waddr`, `alloc_en`, `alloc_addr`, `flush`, `raddr` and `rbusy`.
- **Top level:** keeps the data array, the write-priority logic and the bypass mux.
- The data array is a flop array rather than an inferred RAM, because of the asynchronous reset and multi-write requirement.

## Test plan
- **Reset:** assert `rst_n=0` mid-run after writing r5=0xDEADBEEF, then release → r5 reads 0x0, all `rbusy`=0.
- **Write then read:** port0 writes r3=0x12345678; next cycle read r3 on both ports → 0x12345678.
- **Same-cycle bypass:** port1 writes r7=0xA5A5A5A5 while `raddr[0]`=7 → `rdata[0]`=0xA5A5A5A5 in the same cycle, `rbusy[0]`=0.
- **Write collision:** port0 r9=0x1111 and port1 r9=0x2222 in the same cycle → r9 reads 0x2222 afterwards.
- **Register 0:** write r0=0xFFFFFFFF and alloc r0 → `rdata`=0 and `rbusy`=0 for r0, both immediately and afterwards.
- **Scoreboard:**
  - alloc r4 → next cycle `rbusy`=1 for r4;
  - alloc r4 plus write r4 in the same cycle → r4 stays busy;
  - write r4 alone → busy cleared;
  - alloc r6 with `flush` in the same cycle → r6 not busy.
